// File: rtl/mem_access_stage.sv
// MEM stage plus MEM/WB register: RV32 loads/stores over a variable-latency req/ack port.
// Stalls upstream while an access is outstanding and reports misaligned, illegal and timed-out accesses.
module mem_access_stage #(
  parameter int ADDR_W      = 32,
  parameter int RF_ADDR_W   = 5,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 ValidM,
  input  logic                 RegWriteM,
  input  logic                 MemReadM,
  input  logic                 MemWriteM,
  input  logic [1:0]           ResultSrcM,
  input  logic [2:0]           Funct3M,
  input  logic [RF_ADDR_W-1:0] RdM,
  input  logic [31:0]          PCPlus4M,
  input  logic [31:0]          ALUResultM,
  input  logic [31:0]          WriteDataM,
  output logic                 StallM,
  output logic                 MemReq,
  output logic                 MemWe,
  output logic [ADDR_W-1:0]    MemAddr,
  output logic [3:0]           MemBe,
  output logic [31:0]          MemWData,
  input  logic                 MemAck,
  input  logic [31:0]          MemRData,
  output logic                 ValidW,
  output logic                 RegWriteW,
  output logic [1:0]           ResultSrcW,
  output logic [RF_ADDR_W-1:0] RdW,
  output logic [31:0]          PCPlus4W,
  output logic [31:0]          ALUResultW,
  output logic [31:0]          ReadDataW,
  output logic [1:0]           FaultW
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] WAIT = 1'b1;

  localparam int CNT_W = (TIMEOUT_CYC < 2) ? 2 : $clog2(TIMEOUT_CYC + 1);
  localparam int TO_LAST = (TIMEOUT_CYC == 0) ? 0 : TIMEOUT_CYC - 1;
  localparam logic [CNT_W-1:0] TO_LAST_C = TO_LAST[CNT_W-1:0];

  localparam logic [1:0] FAULT_NONE     = 2'b00;
  localparam logic [1:0] FAULT_MISALIGN = 2'b01;
  localparam logic [1:0] FAULT_TIMEOUT  = 2'b10;
  localparam logic [1:0] FAULT_ILLEGAL  = 2'b11;

  function automatic logic [3:0] laneBe(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'b00:   laneBe = 4'b0001 << off;
      2'b01:   laneBe = off[1] ? 4'b1100 : 4'b0011;
      default: laneBe = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] laneData(input logic [2:0] f3, input logic [31:0] data);
    case (f3[1:0])
      2'b00:   laneData = {4{data[7:0]}};
      2'b01:   laneData = {2{data[15:0]}};
      default: laneData = data;
    endcase
  endfunction

  function automatic logic [31:0] loadExtract(input logic [2:0] f3, input logic [1:0] off,
                                              input logic [31:0] rdata);
    logic [31:0]        sh;
    logic signed [7:0]  bS;
    logic signed [15:0] hS;
    sh = rdata >> {off, 3'b000};
    bS = sh[7:0];
    hS = sh[15:0];
    case (f3)
      3'b000:  loadExtract = {{24{bS[7]}}, bS};
      3'b001:  loadExtract = {{16{hS[15]}}, hS};
      3'b100:  loadExtract = {24'd0, sh[7:0]};
      3'b101:  loadExtract = {16'd0, sh[15:0]};
      default: loadExtract = rdata;
    endcase
  endfunction

  logic [0:0]        state;
  logic [CNT_W-1:0]  waitCnt;
  logic              reqWe_p1;
  logic [ADDR_W-1:0] reqAddr_p1;
  logic [3:0]        reqBe_p1;
  logic [31:0]       reqWData_p1;

  logic              memOp, f3Legal, illegal, misalign, legalOp;
  logic              ackHit, timeoutHit;
  logic [1:0]        faultNext;
  logic [ADDR_W-1:0] addrNow;

  always_comb begin
    memOp    = ValidM & (MemReadM | MemWriteM);
    f3Legal  = MemReadM ? (Funct3M inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101})
                        : (Funct3M inside {3'b000, 3'b001, 3'b010});
    illegal  = memOp & ~f3Legal;
    misalign = memOp & (((Funct3M[1:0] == 2'b01) & ALUResultM[0]) |
                        ((Funct3M[1:0] == 2'b10) & (ALUResultM[1:0] != 2'b00)));
    legalOp  = memOp & ~illegal & ~misalign;
    addrNow  = {ALUResultM[ADDR_W-1:2], 2'b00};
  end

  // Request side: fresh fields from M on issue, latched fields while waiting
  always_comb begin
    MemReq     = 1'b0;
    MemWe      = reqWe_p1;
    MemAddr    = reqAddr_p1;
    MemBe      = reqBe_p1;
    MemWData   = reqWData_p1;
    StallM     = 1'b0;
    ackHit     = 1'b0;
    timeoutHit = 1'b0;
    if (!RESET) begin
      if (state == IDLE) begin
        MemReq   = legalOp;
        MemWe    = MemWriteM;
        MemAddr  = addrNow;
        MemBe    = MemWriteM ? laneBe(Funct3M, ALUResultM[1:0]) : 4'b1111;
        MemWData = laneData(Funct3M, WriteDataM);
        ackHit   = legalOp & MemAck;
        StallM   = legalOp & ~MemAck;
      end else begin
        MemReq     = 1'b1;
        ackHit     = MemAck;
        timeoutHit = (TIMEOUT_CYC != 0) && !MemAck && (waitCnt == TO_LAST_C);
        StallM     = ~MemAck & ~timeoutHit;
      end
    end
  end

  always_comb begin
    if (illegal)         faultNext = FAULT_ILLEGAL;
    else if (misalign)   faultNext = FAULT_MISALIGN;
    else if (timeoutHit) faultNext = FAULT_TIMEOUT;
    else                 faultNext = FAULT_NONE;
  end

  // waitCnt holds the number of request cycles already spent, issue cycle included
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state   <= IDLE;
      waitCnt <= '0;
    end else if (state == IDLE) begin
      if (StallM) begin
        state   <= WAIT;
        waitCnt <= CNT_W'(1);
      end
    end else begin
      if (!StallM) begin
        state   <= IDLE;
        waitCnt <= '0;
      end else begin
        waitCnt <= waitCnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (state == IDLE && MemReq) begin
      reqWe_p1    <= MemWe;
      reqAddr_p1  <= MemAddr;
      reqBe_p1    <= MemBe;
      reqWData_p1 <= MemWData;
    end
  end

  // M -> W boundary
  always_ff @(posedge CLK) begin
    if (RESET) begin
      ValidW     <= 1'b0;
      RegWriteW  <= 1'b0;
      FaultW     <= FAULT_NONE;
      ReadDataW  <= '0;
      ResultSrcW <= '0;
      RdW        <= '0;
      PCPlus4W   <= '0;
      ALUResultW <= '0;
    end else begin
      ResultSrcW <= ResultSrcM;
      RdW        <= RdM;
      PCPlus4W   <= PCPlus4M;
      ALUResultW <= ALUResultM;
      if (StallM || !ValidM) begin
        ValidW    <= 1'b0;
        RegWriteW <= 1'b0;
        FaultW    <= FAULT_NONE;
        ReadDataW <= '0;
      end else begin
        ValidW    <= 1'b1;
        RegWriteW <= RegWriteM & (faultNext == FAULT_NONE);
        FaultW    <= faultNext;
        ReadDataW <= (MemReadM & ackHit) ? loadExtract(Funct3M, ALUResultM[1:0], MemRData) : '0;
      end
    end
  end

endmodule
